// File: rtl/multi_spi_pkg.sv
// Shared definitions for the nibble-wide loader link and its readback transmitter.
package multi_spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2,
      DONE  = 2'd3
   } tx_state_t;

   localparam int DEFAULT_LANES = 4;

   function automatic int calc_beats(input int regsize, input int lanes);
      return regsize / lanes;
   endfunction

endpackage

// File: rtl/multi_spi_tx.sv
// Readback transmitter: sends a REGSIZE-bit word over LANES lines, MSB beat first.
// Define MULTI_SPI_TX_PARITY_EN to append a per-lane even-parity beat.
module multi_spi_tx
   import multi_spi_pkg::*;
#(
   parameter int REGSIZE = 32,
   parameter int LANES   = DEFAULT_LANES
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [REGSIZE-1:0] data_in,
   input  logic               adv,
   input  logic               abort,
   output logic [LANES-1:0]   dout,
   output logic               valid,
   output logic               busy,
   output logic               done
);

   localparam int BEATS = calc_beats(REGSIZE, LANES);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   if ((REGSIZE % LANES) != 0) begin : g_bad_cfg
      $error("multi_spi_tx: REGSIZE must be a multiple of LANES");
   end

   tx_state_t          state_q, state_d;
   logic [REGSIZE-1:0] shreg_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [LANES-1:0]   beat;

   assign beat = shreg_q[REGSIZE-1 -: LANES];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: next-state and output signals get defaults first so no path
   // through the case leaves them unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:  if (load) state_d = SHIFT;
            SHIFT: if (adv && cnt_q == LAST_BEAT) begin
`ifdef MULTI_SPI_TX_PARITY_EN
               state_d = PAR;
`else
               state_d = DONE;
`endif
            end
`ifdef MULTI_SPI_TX_PARITY_EN
            PAR:   if (adv) state_d = DONE;
`endif
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: the shift register is a plain flop bank (not a memory), so it is
   // reset to keep dout defined and zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else if (!abort) begin
         if (state_q == IDLE && load) begin
            shreg_q <= data_in;
            cnt_q   <= '0;
         end else if (state_q == SHIFT && adv && cnt_q != LAST_BEAT) begin
            shreg_q <= shreg_q << LANES;
            cnt_q   <= cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef MULTI_SPI_TX_PARITY_EN
   logic [LANES-1:0] acc_q;

   // Every consumed data beat folds into the accumulator, giving even parity per lane.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (!abort) begin
         if (state_q == IDLE && load)      acc_q <= '0;
         else if (state_q == SHIFT && adv) acc_q <= acc_q ^ beat;
      end
   end
`endif

   // Outputs decode registered state only; nothing flows straight from inputs.
   always_comb begin
      dout  = '0;
      valid = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state_q)
         SHIFT: begin
            dout  = beat;
            valid = 1'b1;
            busy  = 1'b1;
         end
`ifdef MULTI_SPI_TX_PARITY_EN
         PAR: begin
            dout  = acc_q;
            valid = 1'b1;
            busy  = 1'b1;
         end
`endif
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multi_spi_tx.sv
// Directed self-checking bench for multi_spi_tx (REGSIZE=32, LANES=4).
// Parity checks are included when MULTI_SPI_TX_PARITY_EN is defined.
module tb_multi_spi_tx;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [31:0] data_in;
   logic        adv;
   logic        abort;
   logic [3:0]  dout;
   logic        valid;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;

   multi_spi_tx dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .data_in (data_in),
      .adv     (adv),
      .abort   (abort),
      .dout    (dout),
      .valid   (valid),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] nib(input logic [31:0] w, input int i);
      logic [31:0] t;
      t = w >> (28 - 4 * i);
      return t[3:0];
   endfunction

   // Observed vector is {valid, busy, done, dout}.
   task automatic test_reset();
      checks++;
      if ({valid, busy, done, dout} !== 7'b000_0000) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b", {valid, busy, done, dout}, 7'b000_0000);
      end
      adv = 1'b1;
      step();
      step();
      checks++;
      if ({valid, busy, done, dout} !== 7'b000_0000) begin
         errors++;
         $display("FAIL idle_adv_ignored: got %b expected %b", {valid, busy, done, dout}, 7'b000_0000);
      end
      adv = 1'b0;
   endtask

   // Load a word with adv held high; optionally pulse load mid-transfer with another word.
   task automatic run_word(input logic [31:0] word, input string name, input int glitch_at);
      logic [3:0] par;
      logic [6:0] exp;
      par     = 4'h0;
      data_in = word;
      load    = 1'b1;
      adv     = 1'b1;
      step();
      for (int i = 0; i < 8; i++) begin
         if (i == glitch_at) begin
            load    = 1'b1;
            data_in = 32'h5555_5555;
         end else begin
            load = 1'b0;
         end
         exp = {3'b110, nib(word, i)};
         checks++;
         if ({valid, busy, done, dout} !== exp) begin
            errors++;
            $display("FAIL %s beat%0d: got %b expected %b", name, i, {valid, busy, done, dout}, exp);
         end
         par = par ^ nib(word, i);
         step();
      end
      load = 1'b0;
`ifdef MULTI_SPI_TX_PARITY_EN
      exp = {3'b110, par};
      checks++;
      if ({valid, busy, done, dout} !== exp) begin
         errors++;
         $display("FAIL %s parity_beat: got %b expected %b", name, {valid, busy, done, dout}, exp);
      end
      step();
`endif
      checks++;
      if ({valid, busy, done, dout} !== 7'b001_0000) begin
         errors++;
         $display("FAIL %s done_pulse: got %b expected %b", name, {valid, busy, done, dout}, 7'b001_0000);
      end
      step();
      checks++;
      if ({valid, busy, done, dout} !== 7'b000_0000) begin
         errors++;
         $display("FAIL %s after_done: got %b expected %b", name, {valid, busy, done, dout}, 7'b000_0000);
      end
      adv = 1'b0;
   endtask

   task automatic test_stream();
      run_word(32'hDEAD_BEEF, "stream_deadbeef", -1);
   endtask

   task automatic test_stall();
      int         k;
      int         cyc;
      logic [6:0] exp;
      data_in = 32'h1234_5678;
      load    = 1'b1;
      adv     = 1'b0;
      step();
      load = 1'b0;
      k    = 0;
      cyc  = 0;
      while (k < 8 && cyc < 40) begin
         exp = {3'b110, nib(32'h1234_5678, k)};
         checks++;
         if ({valid, busy, done, dout} !== exp) begin
            errors++;
            $display("FAIL stall beat%0d cyc%0d: got %b expected %b", k, cyc, {valid, busy, done, dout}, exp);
         end
         adv = (cyc % 3 == 0);
         step();
         if (adv) k++;
         cyc++;
      end
      checks++;
      if (k != 8) begin
         errors++;
         $display("FAIL stall_timeout: accepted %0d beats expected 8", k);
      end
`ifdef MULTI_SPI_TX_PARITY_EN
      adv = 1'b1;
      step();
`endif
      adv = 1'b0;
      checks++;
      if ({valid, busy, done, dout} !== 7'b001_0000) begin
         errors++;
         $display("FAIL stall_done: got %b expected %b", {valid, busy, done, dout}, 7'b001_0000);
      end
      step();
   endtask

   task automatic test_abort();
      data_in = 32'hCAFE_F00D;
      load    = 1'b1;
      adv     = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({valid, dout} !== {1'b1, nib(32'hCAFE_F00D, i)}) begin
            errors++;
            $display("FAIL abort_pre beat%0d: got %b expected %b", i, {valid, dout}, {1'b1, nib(32'hCAFE_F00D, i)});
         end
         step();
      end
      abort = 1'b1;
      adv   = 1'b0;
      step();
      abort = 1'b0;
      checks++;
      if ({valid, busy, done, dout} !== 7'b000_0000) begin
         errors++;
         $display("FAIL abort_idle: got %b expected %b", {valid, busy, done, dout}, 7'b000_0000);
      end
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done: got %b expected 0", done);
      end
      run_word(32'h0000_000F, "after_abort", -1);
   endtask

   task automatic test_load_while_busy();
      run_word(32'hAAAA_AAAA, "load_ignored", 3);
   endtask

   task automatic test_async_reset();
      data_in = 32'h8765_4321;
      load    = 1'b1;
      adv     = 1'b1;
      step();
      load = 1'b0;
      step();
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({valid, busy, done, dout} !== 7'b000_0000) begin
         errors++;
         $display("FAIL async_reset: got %b expected %b", {valid, busy, done, dout}, 7'b000_0000);
      end
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({valid, busy, done, dout} !== 7'b000_0000) begin
            errors++;
            $display("FAIL post_reset_adv%0d: got %b expected %b", i, {valid, busy, done, dout}, 7'b000_0000);
         end
      end
      adv = 1'b0;
   endtask

`ifdef MULTI_SPI_TX_PARITY_EN
   task automatic test_parity();
      // Beats 0,0,0,0,0,0,1,3 then parity 1^3 = 2.
      run_word(32'h0000_0013, "parity_13", -1);
   endtask
`endif

   initial begin
      rst_n   = 1'b0;
      load    = 1'b0;
      data_in = '0;
      adv     = 1'b0;
      abort   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      test_reset();
      test_stream();
      test_stall();
      test_abort();
      test_load_while_busy();
      test_async_reset();
`ifdef MULTI_SPI_TX_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
